// File: rtl/ticker_message_gen.sv
// Message ticker source: emits one symbol of "HELLO" or "HELP" per enabled KEY edge,
// followed by GAP_LEN blank symbols, and repeats indefinitely.
module ticker_message_gen #(
    parameter int unsigned GAP_LEN = 3
) (
    input  logic       KEY,
    input  logic       SW,
    input  logic       en,
    input  logic       msg_sel,
    output logic [3:0] char_code,
    output logic       char_valid,
    output logic [3:0] index,
    output logic       msg_done
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [3:0] GAP_MAX = 4'(GAP_LEN);

    // Tables are padded to 8 entries so the 3-bit lookup never leaves the array.
    localparam logic [3:0] MSG_HELLO [0:7] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h3, BLANK, BLANK, BLANK};
    localparam logic [3:0] MSG_HELP  [0:7] = '{4'h0, 4'h1, 4'h2, 4'h4, BLANK, BLANK, BLANK, BLANK};

    state_t     state_q;
    logic       selLatched_q;
    logic [3:0] charCode_q;
    logic       charValid_q;
    logic [3:0] index_q;
    logic [3:0] gapCnt_q;

    function automatic logic [3:0] msgChar(input logic sel, input logic [3:0] idx);
        return sel ? MSG_HELP[idx[2:0]] : MSG_HELLO[idx[2:0]];
    endfunction

    function automatic logic [3:0] msgLast(input logic sel);
        return sel ? 4'd3 : 4'd4;
    endfunction

    always_ff @(posedge KEY or negedge SW) begin
        if (!SW) begin
            state_q      <= IDLE;
            selLatched_q <= 1'b0;
            charCode_q   <= BLANK;
            charValid_q  <= 1'b0;
            index_q      <= 4'd0;
            gapCnt_q     <= 4'd0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    state_q      <= EMIT;
                    selLatched_q <= msg_sel;
                    charCode_q   <= msgChar(msg_sel, 4'd0);
                    charValid_q  <= 1'b1;
                    index_q      <= 4'd0;
                end
                EMIT: begin
                    if (index_q != msgLast(selLatched_q)) begin
                        index_q    <= index_q + 4'd1;
                        charCode_q <= msgChar(selLatched_q, index_q + 4'd1);
                    end else if (GAP_MAX == 4'd0) begin
                        // Back-to-back repetition: the next message starts with no blank step.
                        selLatched_q <= msg_sel;
                        charCode_q   <= msgChar(msg_sel, 4'd0);
                        index_q      <= 4'd0;
                    end else begin
                        state_q     <= GAP;
                        charCode_q  <= BLANK;
                        charValid_q <= 1'b0;
                        index_q     <= 4'd0;
                        gapCnt_q    <= 4'd1;
                    end
                end
                GAP: begin
                    if (gapCnt_q < GAP_MAX) begin
                        gapCnt_q <= gapCnt_q + 4'd1;
                    end else begin
                        state_q      <= EMIT;
                        selLatched_q <= msg_sel;
                        charCode_q   <= msgChar(msg_sel, 4'd0);
                        charValid_q  <= 1'b1;
                        index_q      <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign char_code  = charCode_q;
    assign char_valid = charValid_q;
    assign index      = index_q;
    assign msg_done   = (state_q == EMIT) && (index_q == msgLast(selLatched_q));

endmodule
